seq_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor with status flags. It processes WIDTH-bit operands SLICE bits per clock, rippling carry between slices through a register. This trades latency for a short carry chain. It sits beside the single-cycle adder in the ALU datapath and serves wide operands, using a start/busy/done handshake so the controller can stall on it.

---
 rtl/seq_addsub_if.sv | 27 ++
 rtl/seq_addsub.sv | 138 +++++++++++++
 tb/tb_seq_addsub.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_if.sv
// Handshake and result bus between the ALU controller and the sliced adder/subtractor.
interface seq_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             sign;
  logic             zero;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, carry, overflow, sign, zero
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, carry, overflow, sign, zero
  );
endinterface

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: adds SLICE bits per clock with a registered carry
// between slices; result and flags appear only at completion with a one-cycle done.
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input logic        clk,
    input logic        rst_n,
    seq_addsub_if.slave io
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic             sub_q, sub_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;

    logic [SLICE:0]   slice_sum;
    int unsigned      lo;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        c_d        = c_q;
        sub_d      = sub_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        sign_d     = sign_q;
        zero_d     = zero_q;
        slice_sum  = '0;
        lo         = 0;

        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    a_d   = io.a;
                    b_d   = io.op[1] ? ~io.b : io.b;
                    sub_d = io.op[1];
                    case (io.op)
                        2'b00:   c_d = 1'b0;
                        2'b01:   c_d = io.cin;
                        2'b10:   c_d = 1'b1;
                        default: c_d = ~io.cin;
                    endcase
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                lo        = 32'(k_q) * SLICE;
                slice_sum = {1'b0, a_q[lo +: SLICE]} + {1'b0, b_q[lo +: SLICE]}
                          + (SLICE + 1)'(c_q);
                acc_d[lo +: SLICE] = slice_sum[SLICE-1:0];
                c_d = slice_sum[SLICE];
                k_d = k_q + 1'b1;
                // Flags are taken from acc_d so the final slice written this edge is included.
                if (k_q == KW'(N - 1)) begin
                    state_d    = S_IDLE;
                    k_d        = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    result_d   = acc_d;
                    carry_d    = slice_sum[SLICE] ^ sub_q;
                    overflow_d = (a_q[WIDTH-1] ^ acc_d[WIDTH-1]) & (b_q[WIDTH-1] ^ acc_d[WIDTH-1]);
                    sign_d     = acc_d[WIDTH-1];
                    zero_d     = ~|acc_d;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            c_q        <= 1'b0;
            sub_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            c_q        <= c_d;
            sub_q      <= sub_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            sign_q     <= sign_d;
            zero_q     <= zero_d;
        end
    end

    assign io.busy     = busy_q;
    assign io.done     = done_q;
    assign io.result   = result_q;
    assign io.carry    = carry_q;
    assign io.overflow = overflow_q;
    assign io.sign     = sign_q;
    assign io.zero     = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed-vector bench for seq_addsub: 32/8 main instance plus 16/16 and 64/4 sweeps.
module tb_seq_addsub;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    seq_addsub_if #(.WIDTH(32)) i32 ();
    seq_addsub_if #(.WIDTH(16)) i16 ();
    seq_addsub_if #(.WIDTH(64)) i64 ();

    seq_addsub #(.WIDTH(32), .SLICE(8))  u32 (.clk(clk), .rst_n(rst_n), .io(i32.slave));
    seq_addsub #(.WIDTH(16), .SLICE(16)) u16 (.clk(clk), .rst_n(rst_n), .io(i16.slave));
    seq_addsub #(.WIDTH(64), .SLICE(4))  u64 (.clk(clk), .rst_n(rst_n), .io(i64.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        s;
        logic        z;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input int w, input logic [1:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic cin, output logic [63:0] r,
                                  output logic c, output logic v, output logic s, output logic z);
        logic [64:0] mask, bp, sum;
        logic        c0;
        mask = (65'd1 << w) - 65'd1;
        bp   = {1'b0, (op[1] ? ~b : b)} & mask;
        c0   = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? cin : (op == 2'b10) ? 1'b1 : ~cin;
        sum  = ({1'b0, a} & mask) + bp + 65'(c0);
        r    = sum[63:0] & mask[63:0];
        c    = sum[w] ^ op[1];
        v    = (a[w-1] ^ r[w-1]) & (bp[w-1] ^ r[w-1]);
        s    = r[w-1];
        z    = (r == 64'd0);
    endfunction

    task automatic check_out32(input string tag, input vec_t v);
        chk({tag, "_result"},   64'(i32.result),   64'(v.r));
        chk({tag, "_carry"},    64'(i32.carry),    64'(v.c));
        chk({tag, "_overflow"}, 64'(i32.overflow), 64'(v.v));
        chk({tag, "_sign"},     64'(i32.sign),     64'(v.s));
        chk({tag, "_zero"},     64'(i32.zero),     64'(v.z));
    endtask

    task automatic run32(input vec_t v, input string tag);
        int cyc;
        int bn;
        i32.op = v.op; i32.a = v.a; i32.b = v.b; i32.cin = v.cin; i32.start = 1'b1;
        @(posedge clk); #1;
        i32.start = 1'b0;
        i32.a = $urandom; i32.b = $urandom; i32.op = 2'($urandom); i32.cin = 1'($urandom);
        chk({tag, "_busy_e0"}, 64'(i32.busy), 64'd1);
        cyc = 0; bn = 0;
        while (!i32.done && cyc < 20) begin
            i32.start = (cyc == 1);
            @(posedge clk); #1;
            cyc++;
            if (i32.busy) bn++;
        end
        i32.start = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'd4);
        chk({tag, "_busy_run"}, 64'(bn), 64'd3);
        check_out32(tag, v);
        @(posedge clk); #1;
        chk({tag, "_done_low"}, 64'(i32.done), 64'd0);
        chk({tag, "_hold"}, 64'(i32.result), 64'(v.r));
    endtask

    task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [63:0] er;
        logic ec, ev, es, ez;
        int cyc;
        model(16, op, 64'(a), 64'(b), cin, er, ec, ev, es, ez);
        i16.op = op; i16.a = a; i16.b = b; i16.cin = cin; i16.start = 1'b1;
        @(posedge clk); #1;
        i16.start = 1'b0; i16.a = 16'($urandom); i16.b = 16'($urandom);
        cyc = 0;
        while (!i16.done && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w16_latency", 64'(cyc), 64'd1);
        chk("w16_result", 64'(i16.result), er);
        chk("w16_flags", 64'({i16.carry, i16.overflow, i16.sign, i16.zero}), 64'({ec, ev, es, ez}));
    endtask

    task automatic run64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [63:0] er;
        logic ec, ev, es, ez;
        int cyc;
        model(64, op, a, b, cin, er, ec, ev, es, ez);
        i64.op = op; i64.a = a; i64.b = b; i64.cin = cin; i64.start = 1'b1;
        @(posedge clk); #1;
        i64.start = 1'b0; i64.a = {$urandom, $urandom}; i64.b = {$urandom, $urandom};
        cyc = 0;
        while (!i64.done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w64_latency", 64'(cyc), 64'd16);
        chk("w64_result", 64'(i64.result), er);
        chk("w64_flags", 64'({i64.carry, i64.overflow, i64.sign, i64.zero}), 64'({ec, ev, es, ez}));
    endtask

    initial begin
        int cyc;
        vec_t v1, v2;
        n_chk = 0;
        n_err = 0;

        //            op     a             b             cin   result        c     v     s     z
        vecs[0]  = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{2'b10, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{2'b10, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'b11, 32'h80000000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'b01, 32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'b11, 32'h00000010, 32'h00000010, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2'b00, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 32'h0000000A, 32'h00000003, 1'b1, 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        i32.start = 1'b0; i32.op = '0; i32.a = '0; i32.b = '0; i32.cin = 1'b0;
        i16.start = 1'b0; i16.op = '0; i16.a = '0; i16.b = '0; i16.cin = 1'b0;
        i64.start = 1'b0; i64.op = '0; i64.a = '0; i64.b = '0; i64.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset_busy_done", 64'({i32.busy, i32.done}), 64'd0);
        chk("reset_result", 64'(i32.result), 64'd0);
        chk("reset_flags", 64'({i32.carry, i32.overflow, i32.sign, i32.zero}), 64'd0);

        for (int i = 0; i < 12; i++) run32(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: second start lands in the done cycle of the first.
        v1 = '{2'b00, 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0};
        v2 = '{2'b10, 32'h00000030, 32'h00000031, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        i32.op = v1.op; i32.a = v1.a; i32.b = v1.b; i32.cin = v1.cin; i32.start = 1'b1;
        @(posedge clk); #1;
        i32.start = 1'b0;
        cyc = 0;
        while (!i32.done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_lat1", 64'(cyc), 64'd4);
        check_out32("b2b_op1", v1);
        i32.op = v2.op; i32.a = v2.a; i32.b = v2.b; i32.cin = v2.cin; i32.start = 1'b1;
        @(posedge clk); #1;
        i32.start = 1'b0;
        chk("b2b_busy2", 64'({i32.busy, i32.done}), 64'b10);
        chk("b2b_hold1", 64'(i32.result), 64'(v1.r));
        cyc = 0;
        while (!i32.done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_lat2", 64'(cyc), 64'd4);
        check_out32("b2b_op2", v2);

        // Asynchronous reset two cycles into a run.
        i32.op = 2'b00; i32.a = 32'h00000005; i32.b = 32'h00000006; i32.start = 1'b1;
        @(posedge clk); #1;
        i32.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy_done", 64'({i32.busy, i32.done}), 64'd0);
        chk("arst_result", 64'(i32.result), 64'd0);
        chk("arst_flags", 64'({i32.carry, i32.overflow, i32.sign, i32.zero}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i32.done || i32.busy) cyc++;
        end
        chk("arst_no_done", 64'(cyc), 64'd0);
        run32(vecs[5], "post_rst");

        // Parameter sweep against the reference model.
        run16(2'b00, 16'h7FFF, 16'h0001, 1'b0);
        run16(2'b11, 16'h0000, 16'h0000, 1'b1);
        run64(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        run64(2'b10, 64'h8000_0000_0000_0000, 64'h1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run16(2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            run64(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
